// File: rtl/vx_mem_responder_pkg.sv
// vx_mem_responder_pkg
// Shared types and constants for the Vortex L1 memory-bus responder.
// Provides the default bus geometry, the request/response record layouts
// and the index/counter width helpers used by vx_mem_responder and its
// response FIFO.
package vx_mem_responder_pkg;

    localparam int L1_LINE_SIZE         = 64;
    localparam int L1_MEM_ARB_TAG_WIDTH = 8;
    localparam int MEM_ADDR_WIDTH       = 26;
    localparam int MEM_DEPTH_DEFAULT    = 1024;
    localparam int RSP_QUEUE_DEFAULT    = 4;

    // Width of a RAM index; a single-entry RAM still needs a 1-bit index.
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IDX_WIDTH = idxWidth(MEM_DEPTH_DEFAULT);
    localparam int CNT_WIDTH = $clog2(RSP_QUEUE_DEFAULT + 1);

    // Request and response records for the default bus geometry.
    typedef struct packed {
        logic                              rw;
        logic [MEM_ADDR_WIDTH-1:0]         addr;
        logic [L1_LINE_SIZE*8-1:0]         data;
        logic [L1_LINE_SIZE-1:0]           byteen;
        logic [L1_MEM_ARB_TAG_WIDTH-1:0]   tag;
    } mem_req_t;

    typedef struct packed {
        logic [L1_LINE_SIZE*8-1:0]         data;
        logic [L1_MEM_ARB_TAG_WIDTH-1:0]   tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_mem_rsp_fifo.sv
// vx_mem_rsp_fifo
// First-word fall-through FIFO holding read responses. The head entry is
// visible on o_head whenever o_empty is low; a pop advances to the next one.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset (clears pointers)
//   i_push, i_data : write one entry at the tail
//   i_pop          : consume the head entry (ignored when empty)
//   o_head         : current head entry
//   o_empty/o_full : occupancy flags
module vx_mem_rsp_fifo
    import vx_mem_responder_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mem_rsp_t
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_empty,
    output logic o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 r_store [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign o_head   = r_store[r_rdPtr];
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign w_doPush = i_push && (!o_full || i_pop);
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_store[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vx_mem_responder.sv
// vx_mem_responder
// Memory-side responder for the Vortex L1 memory bus. Writes update a
// byte-enabled line RAM; reads are captured from the RAM at accept, travel
// through a LATENCY-stage pipeline and land in a response FIFO that returns
// tagged data in accept order. A credit counter bounds outstanding reads to
// the FIFO depth so the FIFO can never overflow.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   req_valid/req_ready               : request handshake
//   req_rw, req_addr, req_data,
//   req_byteen, req_tag               : request payload (rw=1 write, 0 read)
//   rsp_valid/rsp_ready               : response handshake
//   rsp_data, rsp_tag                 : response payload (0 when no response)
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE  = L1_LINE_SIZE,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int TAG_WIDTH  = L1_MEM_ARB_TAG_WIDTH,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int LATENCY    = 4,
    parameter int RSP_QUEUE  = RSP_QUEUE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_SIZE*8-1:0] req_data,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [DATA_SIZE*8-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready
);

    localparam int IDX_W = idxWidth(MEM_DEPTH);
    localparam int CNT_W = $clog2(RSP_QUEUE + 1);
    localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(RSP_QUEUE);

    typedef struct packed {
        logic [DATA_SIZE*8-1:0] data;
        logic [TAG_WIDTH-1:0]   tag;
    } rsp_t;

    logic [DATA_SIZE*8-1:0] r_mem [MEM_DEPTH];
    logic [LATENCY-1:0]     r_pipeValid;
    rsp_t                   r_pipeRsp [LATENCY];
    logic [CNT_W-1:0]       r_outstanding;

    logic [IDX_W-1:0] w_idx;
    logic             w_accept;
    logic             w_readAccept;
    logic             w_writeAccept;
    logic             w_push;
    logic             w_pop;
    logic             w_fifoEmpty;
    logic             w_fifoFull;
    rsp_t             w_head;

    // Upper address bits alias onto the same line.
    assign w_idx = req_addr[IDX_W-1:0];

    if (ADDR_WIDTH > IDX_W) begin : g_aliasBits
        logic w_unusedAddrBits;
        assign w_unusedAddrBits = ^req_addr[ADDR_WIDTH-1:IDX_W];
    end

    // Ready depends only on the credit count, never on req_valid.
    assign req_ready     = (r_outstanding < MAX_CREDITS);
    assign w_accept      = req_valid && req_ready;
    assign w_readAccept  = w_accept && !req_rw;
    assign w_writeAccept = w_accept && req_rw;

    assign w_push = r_pipeValid[LATENCY-1];
    assign w_pop  = rsp_valid && rsp_ready;

    // Byte-enabled line writes; the RAM itself is never reset.
    always_ff @(posedge clk) begin
        if (w_writeAccept) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req_byteen[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    // Read payload shift register; stage 0 samples the RAM at the accept edge.
    always_ff @(posedge clk) begin
        r_pipeRsp[0].data <= r_mem[w_idx];
        r_pipeRsp[0].tag  <= req_tag;
        for (int s = 1; s < LATENCY; s++) begin
            r_pipeRsp[s] <= r_pipeRsp[s-1];
        end
    end

    // Valid bits of the read pipeline; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipeValid <= '0;
        end else begin
            r_pipeValid[0] <= w_readAccept;
            for (int s = 1; s < LATENCY; s++) begin
                r_pipeValid[s] <= r_pipeValid[s-1];
            end
        end
    end

    // Credits cover reads in the pipeline plus entries in the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_readAccept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    vx_mem_rsp_fifo #(
        .DEPTH (RSP_QUEUE),
        .T     (rsp_t)
    ) u_rspFifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (r_pipeRsp[LATENCY-1]),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    assign rsp_valid = !w_fifoEmpty;
    assign rsp_data  = w_fifoEmpty ? '0 : w_head.data;
    assign rsp_tag   = w_fifoEmpty ? '0 : w_head.tag;

    a_noOverflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_fifoFull && !w_pop));

endmodule
